tile_result_packer: RTL

- Downstream consumer of the per-tile result FIFOs.
- Drains NUM_TILES FP16 result FIFOs under round-robin arbitration.
- Packs up to PACK consecutive results from one tile into a single wide output word, tagged with the tile id and a valid-lane count.
- Feeds the result write-back path through a valid/ready handshake.
- A flush input drains partial (fewer than PACK) tile residues at end of a GEMM.

---
 rtl/tile_result_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tile_result_packer.sv
// Round-robin drain of per-tile FP16 result FIFOs, packing up to PACK results
// from one tile into a tagged wide word on a valid/ready write-back port.
module tile_result_packer #(
  parameter int unsigned NUM_TILES  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PACK       = 8,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic                                           i_clk,
  input  logic                                           i_reset,
  input  logic [NUM_TILES*DATA_WIDTH-1:0]                i_fifo_rd_data,
  input  logic [NUM_TILES-1:0]                           i_fifo_empty,
  input  logic [NUM_TILES*($clog2(FIFO_DEPTH)+1)-1:0]    i_fifo_count,
  output logic [NUM_TILES-1:0]                           o_fifo_rd_en,
  input  logic                                           i_flush,
  output logic [DATA_WIDTH*PACK-1:0]                     o_out_data,
  output logic [$clog2(PACK):0]                          o_out_count,
  output logic [$clog2(NUM_TILES)-1:0]                   o_out_tile_id,
  output logic                                           o_out_valid,
  input  logic                                           i_out_ready,
  output logic                                           o_busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NW = $clog2(PACK) + 1;
  localparam int unsigned LW = $clog2(PACK);
  localparam int unsigned TW = $clog2(NUM_TILES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        ptr_q;
  logic [TW-1:0]        grant_q;
  logic [NW-1:0]        n_q;
  logic [NW-1:0]        rd_cnt_q;
  logic                 cap_valid_q;
  logic [LW-1:0]        cap_idx_q;
  logic [DATA_WIDTH-1:0] lane_q [PACK];
  logic                 valid_q;
  logic                 busy_q;

  logic                 grant_hit;
  logic [TW-1:0]        grant_id;
  logic [NW-1:0]        grant_n;
  int unsigned          idx;
  logic [CW-1:0]        cnt;

  // Round-robin search for the first eligible tile starting at the pointer.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    grant_n   = '0;
    idx       = 0;
    cnt       = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (!grant_hit) begin
        idx = (32'(ptr_q) + 32'(i)) % NUM_TILES;
        cnt = i_fifo_count[idx*CW +: CW];
        if (cnt >= CW'(PACK) || (i_flush && cnt != '0)) begin
          grant_hit = 1'b1;
          grant_id  = TW'(idx);
          grant_n   = (cnt >= CW'(PACK)) ? NW'(PACK) : NW'(cnt);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and read strobe; the empty gate only guards against bad counts.
  always_comb begin
    state_d      = state_q;
    o_fifo_rd_en = '0;
    case (state_q)
      ST_IDLE:   if (grant_hit) state_d = ST_READ;
      ST_READ: begin
        if (rd_cnt_q < n_q && !i_fifo_empty[grant_q]) o_fifo_rd_en[grant_q] = 1'b1;
        if (rd_cnt_q == n_q) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: if (i_out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping, lane capture one cycle behind each issued read.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < PACK; k++) lane_q[k] <= '0;
    end else begin
      valid_q     <= (state_d == ST_OUTPUT);
      busy_q      <= (state_d != ST_IDLE);
      cap_valid_q <= |o_fifo_rd_en;
      cap_idx_q   <= rd_cnt_q[LW-1:0];
      if (state_q == ST_IDLE && grant_hit) begin
        grant_q  <= grant_id;
        n_q      <= grant_n;
        rd_cnt_q <= '0;
        ptr_q    <= (grant_id == TW'(NUM_TILES - 1)) ? '0 : TW'(grant_id + 1'b1);
        for (int k = 0; k < PACK; k++) lane_q[k] <= '0;
      end
      if (state_q == ST_READ && rd_cnt_q < n_q) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (cap_valid_q) lane_q[cap_idx_q] <= i_fifo_rd_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    o_out_data = '0;
    for (int k = 0; k < PACK; k++) o_out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
  end

  assign o_out_count   = n_q;
  assign o_out_tile_id = grant_q;
  assign o_out_valid   = valid_q;
  assign o_busy        = busy_q;

endmodule
